// File: rtl/matmul_unit.sv
// Sequential signed 32-bit matrix multiplier C = A x B: stream in A/B, one MAC per cycle, stream out C.
// Latency: 1 (accept) + max(ra*ca, rb*cb) read + ra*cb*ca compute + ra*cb+1 write cycles.
// No backpressure: the host must present one A/B element per READ cycle and take one C element per WRITE edge.

package matmul_pkg;

    typedef struct packed {
        int rows;
        int cols;
    } matmul_dims_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        READ      = 3'd1,
        CALCULATE = 3'd2,
        WRITE     = 3'd3,
        ERROR     = 3'd4
    } matmul_state_t;

    function automatic logic [31:0] matmul_read_time(input int ra, input int ca, input int rb, input int cb);
        return (ra * ca > rb * cb) ? 32'(ra * ca) : 32'(rb * cb);
    endfunction

    function automatic logic [31:0] matmul_compute_time(input int ra, input int ca, input int cb);
        return 32'(ra * cb * ca);
    endfunction

    function automatic logic [31:0] matmul_write_time(input int ra, input int cb);
        return 32'(ra * cb);
    endfunction

endpackage

module matmul_unit
    import matmul_pkg::*;
#(
    parameter int MAX_ELS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [2:0]  state,
    input  logic [63:0] dims_a,
    input  logic [31:0] in_a,
    input  logic [63:0] dims_b,
    input  logic [31:0] in_b,
    output logic [31:0] out_c
);

    localparam int AW = $clog2(MAX_ELS);

    // Element buffers; contents are don't-care after reset.
    logic [31:0] a_mem [MAX_ELS];
    logic [31:0] b_mem [MAX_ELS];
    logic [31:0] c_mem [MAX_ELS];

    matmul_dims_t da, db;
    assign da = dims_a;
    assign db = dims_b;

    // Dimension checks use 64-bit products so huge dims cannot wrap back into range.
    logic [63:0] prod_a, prod_b, prod_c;
    logic        dims_bad;
    assign prod_a   = {32'd0, da.cols} * {32'd0, da.rows};
    assign prod_b   = {32'd0, db.cols} * {32'd0, db.rows};
    assign prod_c   = {32'd0, da.rows} * {32'd0, db.cols};
    assign dims_bad = (da.rows <= 0) || (da.cols <= 0) || (db.rows <= 0) || (db.cols <= 0)
                   || (da.cols != db.rows)
                   || (prod_a > 64'(MAX_ELS)) || (prod_b > 64'(MAX_ELS)) || (prod_c > 64'(MAX_ELS));

    matmul_state_t state_q, state_d;
    logic [31:0]   out_c_q, out_c_d;
    logic [31:0]   ra_q, ra_d, ca_q, ca_d, cb_q, cb_d;
    logic [31:0]   na_q, na_d, nb_q, nb_d, nc_q, nc_d, rd_time_q, rd_time_d;
    logic [31:0]   cnt_q, cnt_d;
    logic [31:0]   r_q, r_d, c_q, c_d, k_q, k_d;
    logic [31:0]   a_idx_q, a_idx_d, b_idx_q, b_idx_d, c_idx_q, c_idx_d;
    logic [31:0]   acc_q, acc_d;

    logic          a_we, b_we, c_we;
    logic [31:0]   a_rd, b_rd, c_rd, mac_sum;

    assign a_rd    = a_mem[AW'(a_idx_q)];
    assign b_rd    = b_mem[AW'(b_idx_q)];
    assign c_rd    = c_mem[AW'(cnt_q)];
    assign mac_sum = acc_q + a_rd * b_rd;

    assign state = state_q;
    assign out_c = out_c_q;

    // Next-state, counter and buffer-write-enable logic for the whole sequence.
    always_comb begin
        state_d   = state_q;
        out_c_d   = out_c_q;
        ra_d      = ra_q;
        ca_d      = ca_q;
        cb_d      = cb_q;
        na_d      = na_q;
        nb_d      = nb_q;
        nc_d      = nc_q;
        rd_time_d = rd_time_q;
        cnt_d     = cnt_q;
        r_d       = r_q;
        c_d       = c_q;
        k_d       = k_q;
        a_idx_d   = a_idx_q;
        b_idx_d   = b_idx_q;
        c_idx_d   = c_idx_q;
        acc_d     = acc_q;
        a_we      = 1'b0;
        b_we      = 1'b0;
        c_we      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    ra_d      = da.rows;
                    ca_d      = da.cols;
                    cb_d      = db.cols;
                    na_d      = 32'(da.rows * da.cols);
                    nb_d      = 32'(db.rows * db.cols);
                    nc_d      = matmul_write_time(da.rows, db.cols);
                    rd_time_d = matmul_read_time(da.rows, da.cols, db.rows, db.cols);
                    cnt_d     = '0;
                    state_d   = dims_bad ? ERROR : READ;
                end
            end
            READ: begin
                a_we = (cnt_q < na_q);
                b_we = (cnt_q < nb_q);
                if (cnt_q == rd_time_q - 32'd1) begin
                    state_d = CALCULATE;
                    r_d     = '0;
                    c_d     = '0;
                    k_d     = '0;
                    a_idx_d = '0;
                    b_idx_d = '0;
                    c_idx_d = '0;
                    acc_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            CALCULATE: begin
                // Indices advance incrementally: a_idx = r*ca+k, b_idx = k*cb+c, c_idx = r*cb+c.
                if (k_q == ca_q - 32'd1) begin
                    c_we    = 1'b1;
                    acc_d   = '0;
                    k_d     = '0;
                    c_idx_d = c_idx_q + 32'd1;
                    if (c_q == cb_q - 32'd1) begin
                        c_d     = '0;
                        r_d     = r_q + 32'd1;
                        a_idx_d = a_idx_q + 32'd1;
                        b_idx_d = '0;
                        if (r_q == ra_q - 32'd1) begin
                            state_d = WRITE;
                            cnt_d   = '0;
                        end
                    end else begin
                        c_d     = c_q + 32'd1;
                        a_idx_d = a_idx_q - (ca_q - 32'd1);
                        b_idx_d = c_q + 32'd1;
                    end
                end else begin
                    acc_d   = mac_sum;
                    k_d     = k_q + 32'd1;
                    a_idx_d = a_idx_q + 32'd1;
                    b_idx_d = b_idx_q + cb_q;
                end
            end
            WRITE: begin
                if (cnt_q == nc_q) begin
                    state_d = IDLE;
                end else begin
                    out_c_d = c_rd;
                    cnt_d   = cnt_q + 32'd1;
                end
            end
            ERROR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state and counters; reset aborts any operation in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            out_c_q   <= '0;
            ra_q      <= '0;
            ca_q      <= '0;
            cb_q      <= '0;
            na_q      <= '0;
            nb_q      <= '0;
            nc_q      <= '0;
            rd_time_q <= '0;
            cnt_q     <= '0;
            r_q       <= '0;
            c_q       <= '0;
            k_q       <= '0;
            a_idx_q   <= '0;
            b_idx_q   <= '0;
            c_idx_q   <= '0;
            acc_q     <= '0;
        end else begin
            state_q   <= state_d;
            out_c_q   <= out_c_d;
            ra_q      <= ra_d;
            ca_q      <= ca_d;
            cb_q      <= cb_d;
            na_q      <= na_d;
            nb_q      <= nb_d;
            nc_q      <= nc_d;
            rd_time_q <= rd_time_d;
            cnt_q     <= cnt_d;
            r_q       <= r_d;
            c_q       <= c_d;
            k_q       <= k_d;
            a_idx_q   <= a_idx_d;
            b_idx_q   <= b_idx_d;
            c_idx_q   <= c_idx_d;
            acc_q     <= acc_d;
        end
    end

    // Buffer writes: A/B captured during READ, C result stored on the last MAC of each dot product.
    always_ff @(posedge clk) begin
        if (a_we) a_mem[AW'(cnt_q)] <= in_a;
        if (b_we) b_mem[AW'(cnt_q)] <= in_b;
        if (c_we) c_mem[AW'(c_idx_q)] <= mac_sum;
    end

endmodule

// File: tb/tb_matmul_unit.sv
// Directed bench for matmul_unit: dimension errors, small hand-computed products, 16x16 random runs, mid-run reset.
// Inputs driven and outputs sampled on the falling edge.
// Host always supplies data; the DUT applies no backpressure.

module tb_matmul_unit;
    import matmul_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  state;
    logic [63:0] dims_a, dims_b;
    logic [31:0] in_a, in_b, out_c;

    int n_cmp = 0;
    int n_bad = 0;

    int ta [256];
    int tm [256];
    int ge [256];

    matmul_unit #(.MAX_ELS(256)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .state  (state),
        .dims_a (dims_a),
        .in_a   (in_a),
        .dims_b (dims_b),
        .in_b   (in_b),
        .out_c  (out_c)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d expected=%0d", tag, $signed(got), $signed(exp));
        end
    endtask

    // Reference product for random runs, 32-bit wrapping arithmetic.
    task automatic model(input int ra, input int ca, input int cb);
        for (int r = 0; r < ra; r++)
            for (int c = 0; c < cb; c++) begin
                int s;
                s = 0;
                for (int k = 0; k < ca; k++) s += ta[r*ca+k] * tm[k*cb+c];
                ge[r*cb+c] = s;
            end
    endtask

    task automatic run_err(input logic [63:0] da, input logic [63:0] db, input string tag, input logic [31:0] held);
        @(negedge clk);
        dims_a = da;
        dims_b = db;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_err_state"}, 32'(state), 32'(ERROR));
        check({tag, "_err_outc"}, out_c, held);
        @(negedge clk);
        check({tag, "_idle_state"}, 32'(state), 32'(IDLE));
    endtask

    // Full run; abort_at >= 0 asserts reset after that many CALCULATE cycles.
    task automatic run_mm(input int ra, input int ca, input int cb, input string tag, input int abort_at);
        int rt, na, nb, nc, cyc;
        na = ra * ca;
        nb = ca * cb;
        nc = ra * cb;
        rt = (na > nb) ? na : nb;
        @(negedge clk);
        dims_a = {ra, ca};
        dims_b = {ca, cb};
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_read_enter"}, 32'(state), 32'(READ));
        for (int i = 0; i < rt; i++) begin
            in_a = (i < na) ? ta[i] : 32'd0;
            in_b = (i < nb) ? tm[i] : 32'd0;
            if (i == rt - 1) check({tag, "_read_last"}, 32'(state), 32'(READ));
            @(negedge clk);
        end
        check({tag, "_calc_enter"}, 32'(state), 32'(CALCULATE));
        cyc = 0;
        while (state == CALCULATE && cyc < 20000) begin
            if (cyc == abort_at) begin
                rst = 1'b1;
                #1;
                check({tag, "_abort_state"}, 32'(state), 32'(IDLE));
                check({tag, "_abort_outc"}, out_c, 32'd0);
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            cyc++;
            @(negedge clk);
        end
        check({tag, "_calc_len"}, 32'(cyc), matmul_compute_time(ra, ca, cb));
        check({tag, "_write_enter"}, 32'(state), 32'(WRITE));
        for (int j = 0; j < nc; j++) begin
            @(negedge clk);
            check($sformatf("%s_c%0d", tag, j), out_c, ge[j]);
        end
        @(negedge clk);
        check({tag, "_end_state"}, 32'(state), 32'(IDLE));
        check({tag, "_end_outc"}, out_c, ge[nc-1]);
    endtask

    task automatic load_2x2;
        ta[0] = 1; ta[1] = 2; ta[2] = 3; ta[3] = 4;
        tm[0] = 1; tm[1] = 2; tm[2] = 3; tm[3] = 4;
        ge[0] = 7; ge[1] = 10; ge[2] = 15; ge[3] = 22;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        dims_a = '0;
        dims_b = '0;
        in_a   = '0;
        in_b   = '0;
        #3;
        check("reset_state", 32'(state), 32'(IDLE));
        check("reset_outc", out_c, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_err({32'sd1000, 32'sd1000}, {32'sd1000, 32'sd1000}, "oversize", 32'd0);
        run_err({32'sd2, 32'sd3}, {32'sd4, 32'sd2}, "mismatch", 32'd0);
        run_err({32'sd0, 32'sd10}, {32'sd10, 32'sd0}, "zero", 32'd0);

        load_2x2();
        run_mm(2, 2, 2, "mm2x2", -1);

        // Idle with start low holds state and output.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_hold_state", 32'(state), 32'(IDLE));
            check("idle_hold_outc", out_c, 32'd22);
        end

        // A row count beyond MAX_ELS/other dim product, and a negative dim, are rejected; out_c keeps 22.
        run_err({32'sd17, 32'sd16}, {32'sd16, 32'sd1}, "rows17", 32'd22);
        run_err({-32'sd2, 32'sd2}, {32'sd2, 32'sd2}, "negdim", 32'd22);

        // 2x3 * 3x1: A is longer than B.
        ta[0] = 1; ta[1] = -2; ta[2] = 3; ta[3] = 4; ta[4] = 5; ta[5] = -6;
        tm[0] = 7; tm[1] = 8; tm[2] = 9;
        ge[0] = 18; ge[1] = 14;
        run_mm(2, 3, 1, "mm2x3x1", -1);

        // 1x2 * 2x3: B is longer than A.
        ta[0] = 2; ta[1] = -1;
        tm[0] = 1; tm[1] = 2; tm[2] = 3; tm[3] = 4; tm[4] = 5; tm[5] = 6;
        ge[0] = -2; ge[1] = -1; ge[2] = 0;
        run_mm(1, 2, 3, "mm1x2x3", -1);

        // Two back-to-back 16x16 random runs, no reset between them.
        for (int run = 0; run < 2; run++) begin
            for (int i = 0; i < 256; i++) begin
                ta[i] = int'($urandom);
                tm[i] = (run == 0) ? int'($urandom_range(0, 2000)) - 1000 : int'($urandom);
            end
            model(16, 16, 16);
            run_mm(16, 16, 16, $sformatf("mm16_r%0d", run), -1);
        end

        // Reset in the middle of CALCULATE, then a clean 2x2 run.
        load_2x2();
        run_mm(2, 2, 2, "abort", 3);
        check("post_abort_state", 32'(state), 32'(IDLE));
        run_mm(2, 2, 2, "mm2x2_again", -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
